slow_clk_monitor: RTL and testbench



---
 rtl/slow_clk_monitor.sv | 87 ++++++++
 tb/tb_slow_clk_monitor.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/slow_clk_monitor.sv
// slow_clk_monitor: synchronizes a slow clock into the clk domain, emits edge ticks,
// measures period/high time and flags loss of the slow clock.
module slow_clk_monitor #(
    parameter int CNT_WIDTH   = 24,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 slow_in,
    output logic                 rise_tick,
    output logic                 fall_tick,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic                 period_valid,
    output logic                 period_update,
    output logic                 clk_lost
);
    localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, LOCKED = 2'd2;
    localparam logic [CNT_WIDTH-1:0] TMO = CNT_WIDTH'(TIMEOUT);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q, rise_q, fall_q;
    logic                   seen_q, seen_d, valid_q, valid_d;
    logic                   upd_q, upd_d, lost_q, lost_d;
    logic [1:0]             state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, hcnt_q, hcnt_d;
    logic [CNT_WIDTH-1:0]   per_q, per_d, high_q, high_d;
    logic                   sync, capture, timeout;

    assign sync    = sync_q[SYNC_STAGES-1];
    assign capture = rise_q && state_q != IDLE;
    // an edge landing on the saturation cycle wins over the timeout
    assign timeout = !rise_q && state_q != IDLE && cnt_q >= TMO;

    always_comb begin
        cnt_d   = rise_q ? CNT_WIDTH'(1) : (cnt_q >= TMO ? TMO : cnt_q + 1'b1);
        hcnt_d  = fall_q ? cnt_q : hcnt_q;
        seen_d  = fall_q ? 1'b1 : (rise_q ? 1'b0 : seen_q);
        state_d = timeout ? IDLE : (rise_q ? (state_q == IDLE ? ARMED : LOCKED) : state_q);
        per_d   = capture ? cnt_q : (timeout ? '0 : per_q);
        high_d  = capture ? (seen_q ? hcnt_q : '0) : (timeout ? '0 : high_q);
        valid_d = capture || (valid_q && !timeout);
        upd_d   = capture;
        lost_d  = timeout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            seen_q  <= 1'b0;
            valid_q <= 1'b0;
            upd_q   <= 1'b0;
            lost_q  <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            hcnt_q  <= '0;
            per_q   <= '0;
            high_q  <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], slow_in};
            prev_q  <= sync;
            rise_q  <= sync && !prev_q;
            fall_q  <= !sync && prev_q;
            seen_q  <= seen_d;
            valid_q <= valid_d;
            upd_q   <= upd_d;
            lost_q  <= lost_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hcnt_q  <= hcnt_d;
            per_q   <= per_d;
            high_q  <= high_d;
        end
    end

    assign rise_tick     = rise_q;
    assign fall_tick     = fall_q;
    assign period        = per_q;
    assign high_time     = high_q;
    assign period_valid  = valid_q;
    assign period_update = upd_q;
    assign clk_lost      = lost_q;
endmodule

// File: tb/tb_slow_clk_monitor.sv
// tb_slow_clk_monitor: scoreboard bench; expected captures are queued as slow_in rises are driven.
module tb_slow_clk_monitor;
    localparam int CW  = 16;
    localparam int TMO = 50;

    logic          clk, rst_n, slow_in;
    logic          rise_tick, fall_tick, period_valid, period_update, clk_lost;
    logic [CW-1:0] period, high_time;

    int vectors = 0, miscompares = 0, lost_cnt = 0;
    int rises = 0, ph = 0, pl = 0, lat;
    int exp_p[$], exp_h[$];

    slow_clk_monitor #(.CNT_WIDTH(CW), .SYNC_STAGES(2), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .slow_in(slow_in),
        .rise_tick(rise_tick), .fall_tick(fall_tick),
        .period(period), .high_time(high_time),
        .period_valid(period_valid), .period_update(period_update), .clk_lost(clk_lost)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // a rise closes the previous slow cycle; from the second rise on it must be captured
    task automatic rise_hold(input int h);
        if (rises > 0) begin
            exp_p.push_back(ph + pl > TMO ? TMO : ph + pl);
            exp_h.push_back(ph);
        end
        rises++;
        ph = h;
        slow_in = 1;
        repeat (h) @(negedge clk);
    endtask

    task automatic cyc(input int h, input int l);
        rise_hold(h);
        pl = l;
        slow_in = 0;
        repeat (l) @(negedge clk);
    endtask

    always @(negedge clk) if (rst_n) begin
        if (period_update) begin
            check("update_expected", 32'(exp_p.size() > 0), 1);
            if (exp_p.size() > 0) begin
                check("period", 32'(period), exp_p.pop_front());
                check("high_time", 32'(high_time), exp_h.pop_front());
                check("valid_on_update", 32'(period_valid), 1);
            end
        end
        if (clk_lost) begin
            lost_cnt++;
            check("lost_period", 32'(period), 0);
            check("lost_high", 32'(high_time), 0);
            check("lost_valid", 32'(period_valid), 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 0;
        slow_in = 0;
        repeat (10) @(negedge clk) slow_in = ~slow_in;
        check("rst_rise", 32'(rise_tick), 0);
        check("rst_fall", 32'(fall_tick), 0);
        check("rst_period", 32'(period), 0);
        check("rst_high", 32'(high_time), 0);
        check("rst_valid", 32'(period_valid), 0);
        check("rst_update", 32'(period_update), 0);
        check("rst_lost", 32'(clk_lost), 0);
        slow_in = 0;
        repeat (4) @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
        // edge latency and width
        slow_in = 1;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); @(negedge clk);
            if (rise_tick) begin lat = k; break; end
        end
        check("rise_latency", lat, 3);
        @(posedge clk); @(negedge clk);
        check("rise_width", 32'(rise_tick), 0);
        repeat (2) @(negedge clk);
        slow_in = 0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); @(negedge clk);
            if (fall_tick) begin lat = k; break; end
        end
        check("fall_latency", lat, 3);
        @(posedge clk); @(negedge clk);
        check("fall_width", 32'(fall_tick), 0);
        check("armed_valid", 32'(period_valid), 0);
        rst_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        rises = 0;
        // lock on a 10-cycle, 50% square wave
        cyc(5, 5);
        check("first_rise_only_arms", 32'(period_valid), 0);
        repeat (6) cyc(5, 5);
        check("locked_valid", 32'(period_valid), 1);
        // loss of clock
        repeat (120) @(negedge clk);
        check("lost_once", lost_cnt, 1);
        check("idle_valid", 32'(period_valid), 0);
        rises = 0;
        cyc(5, 5);
        check("relock_needs_two", 32'(period_valid), 0);
        repeat (3) cyc(5, 5);
        check("relocked_valid", 32'(period_valid), 1);
        // period change with a mixed transition cycle
        repeat (3) cyc(3, 7);
        cyc(3, 8);
        repeat (4) cyc(8, 8);
        // period equal to the timeout stays locked
        repeat (4) cyc(25, 25);
        check("boundary_no_lost", lost_cnt, 1);
        check("boundary_valid", 32'(period_valid), 1);
        // asynchronous reset mid-period while locked
        rise_hold(10);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        check("async_period", 32'(period), 0);
        check("async_high", 32'(high_time), 0);
        check("async_valid", 32'(period_valid), 0);
        check("async_update", 32'(period_update), 0);
        check("async_rise", 32'(rise_tick), 0);
        slow_in = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        rises = 0;
        check("sb_drained_at_reset", exp_p.size(), 0);
        cyc(10, 10);
        check("post_reset_arm_only", 32'(period_valid), 0);
        repeat (3) cyc(10, 10);
        check("post_reset_valid", 32'(period_valid), 1);
        check("final_lost_count", lost_cnt, 1);
        check("sb_drained_final", exp_p.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
